// File: rtl/kp_calc_core.sv
// Keypad calculator core: hex digits shift into an entry register, and a
// four-state sequencer runs one register-file operation at a time.
// Optional macro KP_CALC_SAT_EN saturates ADD/SUB instead of wrapping.
module kp_calc_core #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             carry_flag,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_DONE} state_t;

  localparam logic [2:0] OP_LOAD = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_AND = 3'd3,
                         OP_OR   = 3'd4, OP_XOR = 3'd5, OP_SHL = 3'd6, OP_CLR = 3'd7;

  state_t                        state_q, state_d;
  logic [2:0]                    op_q, op_d;
  logic [AW-1:0]                 dst_q, dst_d, srca_q, srca_d, srcb_q, srcb_d;
  logic [WIDTH-1:0]              a_q, a_d, b_q, b_d, ent_q, ent_d, entry_q, entry_d;
  logic [NREGS-1:0][WIDTH-1:0]   regs_q, regs_d;
  logic [WIDTH-1:0]              result_q, result_d;
  logic                          zero_q, zero_d, carry_q, carry_d;
  logic                          busy_q, busy_d, done_q, done_d;
  logic                          armed_q, armed_d;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] add_res, sub_res, alu_res;
  logic             alu_cy;
  logic             key_ok, op_ok;

  // Strobes are blanked on the first edge after reset release.
  assign key_ok = key_valid & armed_q;
  assign op_ok  = op_valid & armed_q;

  assign sum_w  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_w = {1'b0, a_q} - {1'b0, b_q};

`ifdef KP_CALC_SAT_EN
  assign add_res = sum_w[WIDTH]  ? {WIDTH{1'b1}} : sum_w[WIDTH-1:0];
  assign sub_res = diff_w[WIDTH] ? {WIDTH{1'b0}} : diff_w[WIDTH-1:0];
`else
  assign add_res = sum_w[WIDTH-1:0];
  assign sub_res = diff_w[WIDTH-1:0];
`endif

  always_comb begin
    alu_res = '0;
    alu_cy  = 1'b0;
    case (op_q)
      OP_LOAD: alu_res = ent_q;
      OP_ADD:  begin alu_res = add_res; alu_cy = sum_w[WIDTH]; end
      OP_SUB:  begin alu_res = sub_res; alu_cy = diff_w[WIDTH]; end
      OP_AND:  alu_res = a_q & b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_XOR:  alu_res = a_q ^ b_q;
      OP_SHL:  begin alu_res = {a_q[WIDTH-2:0], 1'b0}; alu_cy = a_q[WIDTH-1]; end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    dst_d    = dst_q;
    srca_d   = srca_q;
    srcb_d   = srcb_q;
    a_d      = a_q;
    b_d      = b_q;
    ent_d    = ent_q;
    entry_d  = entry_q;
    regs_d   = regs_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = done_q;
    armed_d  = 1'b1;
    case (state_q)
      S_IDLE: if (op_ok) begin
        state_d = S_FETCH;
        op_d    = op;
        dst_d   = dst;
        srca_d  = src_a;
        srcb_d  = src_b;
        busy_d  = 1'b1;
      end
      S_FETCH: begin
        a_d     = regs_q[srca_q];
        b_d     = regs_q[srcb_q];
        ent_d   = entry_q;
        if (op_q == OP_LOAD) entry_d = '0;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_CLR) regs_d = '0;
        else                regs_d[dst_q] = alu_res;
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_cy;
        done_d   = 1'b1;
        state_d  = S_DONE;
      end
      default: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
    // Applied after the LOAD clear so a coincident key lands in a clean entry.
    if (key_ok) entry_d = {entry_d[WIDTH-5:0], key_code};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      dst_q    <= '0;
      srca_q   <= '0;
      srcb_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ent_q    <= '0;
      entry_q  <= '0;
      regs_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      srca_q   <= srca_d;
      srcb_q   <= srcb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ent_q    <= ent_d;
      entry_q  <= entry_d;
      regs_q   <= regs_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      armed_q  <= armed_d;
    end
  end

  assign result     = result_q;
  assign zero_flag  = zero_q;
  assign carry_flag = carry_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_kp_calc_core.sv
// Directed bench for kp_calc_core (WIDTH=8, NREGS=4); expectations hand-computed.
module tb_kp_calc_core;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic       op_valid;
  logic [2:0] op;
  logic [1:0] dst, src_a, src_b;
  logic [7:0] result;
  logic       zero_flag, carry_flag, busy, done;

  int n_chk  = 0;
  int n_pass = 0;
  int lat;
  int dones;

  kp_calc_core #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .op_valid(op_valid), .op(op), .dst(dst), .src_a(src_a), .src_b(src_b),
    .result(result), .zero_flag(zero_flag), .carry_flag(carry_flag),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic key(input logic [3:0] k);
    @(negedge clk); key_valid = 1'b1; key_code = k;
    @(negedge clk); key_valid = 1'b0;
  endtask

  // Returns the number of cycles from the accept edge to the done pulse.
  task automatic do_op(input logic [2:0] o, input logic [1:0] d, input logic [1:0] sa,
                       input logic [1:0] sb, output int l);
    @(negedge clk); op_valid = 1'b1; op = o; dst = d; src_a = sa; src_b = sb;
    @(negedge clk); op_valid = 1'b0; l = 1;
    while (!done && l < 10) begin @(negedge clk); l++; end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b1; key_code = 4'h9;
    op_valid = 1'b1; op = 3'd1; dst = 2'd0; src_a = 2'd0; src_b = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 8'h00);
    chk("rst_zero", zero_flag, 1'b1);
    chk("rst_carry", carry_flag, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    // Release just before a rising edge with strobes still high.
    #4 rst_n = 1'b1;
    @(negedge clk); key_valid = 1'b0; op_valid = 1'b0;
    chk("release_busy", busy, 1'b0);
    chk("release_entry", dut.entry_q, 8'h00);

    key(4'h3); key(4'hA); key(4'h5);
    chk("entry_wrap", dut.entry_q, 8'hA5);
    do_op(3'd0, 2'd1, 2'd0, 2'd0, lat);
    chk("load_lat", lat, 3);
    chk("load_reg1", dut.regs_q[1], 8'hA5);
    chk("load_entry", dut.entry_q, 8'h00);
    chk("load_carry", carry_flag, 1'b0);

    key(4'hF); key(4'h0); do_op(3'd0, 2'd0, 2'd0, 2'd0, lat);
    key(4'h2); key(4'h0); do_op(3'd0, 2'd1, 2'd0, 2'd0, lat);
    do_op(3'd1, 2'd2, 2'd0, 2'd1, lat);
`ifdef KP_CALC_SAT_EN
    chk("add_result", result, 8'hFF);
`else
    chk("add_result", result, 8'h10);
`endif
    chk("add_carry", carry_flag, 1'b1);
    chk("add_lat", lat, 3);

    key(4'h5); do_op(3'd0, 2'd0, 2'd0, 2'd0, lat);
    key(4'h5); do_op(3'd0, 2'd1, 2'd0, 2'd0, lat);
    // SUB, with a second op request held through FETCH and EXEC.
    @(negedge clk); op_valid = 1'b1; op = 3'd2; dst = 2'd0; src_a = 2'd0; src_b = 2'd1;
    @(negedge clk); op = 3'd4; dst = 2'd3; dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      if (i == 1) op_valid = 1'b0;
      @(negedge clk);
    end
    chk("sub_result", result, 8'h00);
    chk("sub_zero", zero_flag, 1'b1);
    chk("sub_carry", carry_flag, 1'b0);
    chk("busy_drop_dones", dones, 1);
    chk("busy_drop_reg3", dut.regs_q[3], 8'h00);

    // Reset while in EXEC.
    @(negedge clk); op_valid = 1'b1; op = 3'd1; dst = 2'd3; src_a = 2'd0; src_b = 2'd1;
    @(negedge clk); op_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    chk("abort_reg3", dut.regs_q[3], 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_zero", zero_flag, 1'b1);
    chk("abort_done", done, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Key 7 on the LOAD FETCH edge.
    key(4'h1); key(4'h2);
    @(negedge clk); op_valid = 1'b1; op = 3'd0; dst = 2'd2;
    @(negedge clk); op_valid = 1'b0; key_valid = 1'b1; key_code = 4'h7;
    @(negedge clk); key_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("coinc_entry", dut.entry_q, 8'h07);
    chk("coinc_reg2", dut.regs_q[2], 8'h12);
    do_op(3'd7, 2'd0, 2'd0, 2'd0, lat);
    chk("clr_regs", dut.regs_q, 32'h0);
    chk("clr_result", result, 8'h00);
    chk("clr_zero", zero_flag, 1'b1);

    // reg0=0x81, reg1=0x0F; entry holds 0x07 so two keys fully replace it.
    key(4'h8); key(4'h1); do_op(3'd0, 2'd0, 2'd0, 2'd0, lat);
    key(4'h0); key(4'hF); do_op(3'd0, 2'd1, 2'd0, 2'd0, lat);
    do_op(3'd6, 2'd3, 2'd0, 2'd0, lat);
    chk("shl_result", result, 8'h02);
    chk("shl_carry", carry_flag, 1'b1);
    do_op(3'd5, 2'd3, 2'd0, 2'd1, lat);
    chk("xor_result", result, 8'h8E);
    chk("xor_carry", carry_flag, 1'b0);
    do_op(3'd3, 2'd3, 2'd0, 2'd1, lat);
    chk("and_result", result, 8'h01);
    do_op(3'd4, 2'd3, 2'd0, 2'd1, lat);
    chk("or_result", result, 8'h8F);
    do_op(3'd2, 2'd2, 2'd1, 2'd0, lat);
`ifdef KP_CALC_SAT_EN
    chk("sub_borrow_result", result, 8'h00);
`else
    chk("sub_borrow_result", result, 8'h8E);
`endif
    chk("sub_borrow_carry", carry_flag, 1'b1);
    do_op(3'd1, 2'd0, 2'd0, 2'd0, lat);
`ifdef KP_CALC_SAT_EN
    chk("self_add_reg0", dut.regs_q[0], 8'hFF);
`else
    chk("self_add_reg0", dut.regs_q[0], 8'h02);
`endif
    chk("self_add_carry", carry_flag, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
